// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: opcodes, state codes,
// datapath select codes and the per-state control decode.
package multicycle_control_pkg;

   localparam int unsigned StateW = 4;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpAddi  = 6'h08;

   localparam logic [StateW-1:0] StFetch  = 4'd0;
   localparam logic [StateW-1:0] StDecode = 4'd1;
   localparam logic [StateW-1:0] StMemAdr = 4'd2;
   localparam logic [StateW-1:0] StMemRd  = 4'd3;
   localparam logic [StateW-1:0] StMemWb  = 4'd4;
   localparam logic [StateW-1:0] StMemWr  = 4'd5;
   localparam logic [StateW-1:0] StExec   = 4'd6;
   localparam logic [StateW-1:0] StRwb    = 4'd7;
   localparam logic [StateW-1:0] StBranch = 4'd8;
   localparam logic [StateW-1:0] StJump   = 4'd9;
   localparam logic [StateW-1:0] StAddiEx = 4'd10;
   localparam logic [StateW-1:0] StAddiWb = 4'd11;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   localparam logic [1:0] SrcBReg    = 2'b00;
   localparam logic [1:0] SrcBFour   = 2'b01;
   localparam logic [1:0] SrcBImm    = 2'b10;
   localparam logic [1:0] SrcBImmSh2 = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   // Moore decode; mem_ready only qualifies the FETCH loads and the MEMWR completion.
   function automatic ctrl_t state_ctrl(input logic [StateW-1:0] st, input logic mem_ready);
      ctrl_t c;
      c = '0;
      case (st)
         StFetch: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SrcBFour;
            c.alu_op    = AluOpAdd;
            c.pc_source = PcSrcAlu;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
         end
         StDecode: begin
            c.alu_src_b = SrcBImmSh2;
            c.alu_op    = AluOpAdd;
         end
         StMemAdr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBImm;
            c.alu_op    = AluOpAdd;
         end
         StMemRd: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         StMemWb: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         StMemWr: begin
            c.mem_write  = 1'b1;
            c.i_or_d     = 1'b1;
            c.instr_done = mem_ready;
         end
         StExec: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBReg;
            c.alu_op    = AluOpFunct;
         end
         StRwb: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
         end
         StBranch: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SrcBReg;
            c.alu_op        = AluOpSub;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PcSrcAluOut;
            c.instr_done    = 1'b1;
         end
         StJump: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PcSrcJump;
            c.instr_done = 1'b1;
         end
         StAddiEx: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBImm;
            c.alu_op    = AluOpAdd;
         end
         StAddiWb: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencing controller and the multi-cycle datapath/memory.
interface multicycle_control_if #(
   parameter int unsigned COUNT_WIDTH = 32
);
   import multicycle_control_pkg::*;

   logic [5:0]             opcode;
   logic                   mem_ready;
   logic                   pc_write;
   logic                   pc_write_cond;
   logic                   i_or_d;
   logic                   mem_read;
   logic                   mem_write;
   logic                   ir_write;
   logic                   mem_to_reg;
   logic                   reg_dst;
   logic                   reg_write;
   logic                   alu_src_a;
   logic [1:0]             alu_src_b;
   logic [1:0]             alu_op;
   logic [1:0]             pc_source;
   logic                   instr_done;
   logic                   illegal_op;
   logic [COUNT_WIDTH-1:0] instr_count;
   logic [StateW-1:0]      state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
             illegal_op, instr_count, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
             illegal_op, instr_count, state
   );

endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle datapath: next-state logic, output decode
// and a retired-instruction counter.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);

   logic [StateW-1:0]      state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   illegal;
   ctrl_t                  ctrl_raw;
   ctrl_t                  ctrl;

   always_comb begin
      state_d = state_q;
      illegal = 1'b0;
      case (state_q)
         StFetch:  if (bus.mem_ready) state_d = StDecode;
         StDecode: begin
            case (bus.opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExec;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiEx;
               default: begin
                  state_d = StFetch;
                  illegal = 1'b1;
               end
            endcase
         end
         StMemAdr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
         StMemRd:  if (bus.mem_ready) state_d = StMemWb;
         StMemWr:  if (bus.mem_ready) state_d = StFetch;
         StExec:   state_d = StRwb;
         StAddiEx: state_d = StAddiWb;
         StMemWb, StRwb, StBranch, StJump, StAddiWb: state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   assign ctrl_raw = state_ctrl(state_q, bus.mem_ready);
   // Reset masks every output combinationally so a request in flight drops immediately.
   assign ctrl     = rst ? '0 : ctrl_raw;
   assign count_d  = ctrl_raw.instr_done ? count_q + COUNT_WIDTH'(1) : count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.i_or_d        = ctrl.i_or_d;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.instr_done    = ctrl.instr_done;
   assign bus.illegal_op    = illegal & ~rst;
   assign bus.instr_count   = rst ? '0 : count_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs, a negedge monitor
// pops and compares against a 32-bit and a 4-bit-counter instance driven identically.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic       mem_ready = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_if #(.COUNT_WIDTH(32)) bus_w ();
   multicycle_control_if #(.COUNT_WIDTH(4))  bus_n ();

   assign bus_w.opcode    = opcode;
   assign bus_w.mem_ready = mem_ready;
   assign bus_n.opcode    = opcode;
   assign bus_n.mem_ready = mem_ready;

   multicycle_control #(.COUNT_WIDTH(32)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));
   multicycle_control #(.COUNT_WIDTH(4))  dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   typedef struct {
      int          idx;
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic        done;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;
   int   cyc_no  = 0;

   // Field order: pw pwc iod mr mw irw m2r rd rw sa | sb aop ps
   function automatic logic [15:0] ctrl_for(input logic [3:0] st, input logic rdy);
      case (st)
         4'd0:    return {rdy, 4'b0010, rdy, 4'b0000, 6'b01_00_00};
         4'd1:    return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
         4'd2:    return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
         4'd3:    return 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
         4'd4:    return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
         4'd5:    return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
         4'd6:    return 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
         4'd7:    return 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
         4'd8:    return 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
         4'd9:    return 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
         4'd10:   return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
         4'd11:   return 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic done_for(input logic [3:0] st, input logic rdy);
      return (st == 4'd4) || (st == 4'd7) || (st == 4'd8) || (st == 4'd9) ||
             (st == 4'd11) || ((st == 4'd5) && rdy);
   endfunction

   task automatic cyc(input logic r, input logic [5:0] op, input logic rdy, input int st,
                      input logic ill);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      opcode    = op;
      mem_ready = rdy;
      e.idx  = cyc_no;
      e.st   = 4'(st);
      e.ctrl = r ? 16'h0000 : ctrl_for(4'(st), rdy);
      e.done = !r && done_for(4'(st), rdy);
      e.ill  = ill;
      e.cnt  = r ? 32'd0 : 32'(exp_cnt);
      exp_q.push_back(e);
      cyc_no++;
      if (r) exp_cnt = 0;
      else if (e.done) exp_cnt++;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h want %0h", name, idx, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("state", e.idx, 32'(bus_w.state), 32'(e.st));
         check("state_n", e.idx, 32'(bus_n.state), 32'(e.st));
         check("ctrl", e.idx, 32'({bus_w.pc_write, bus_w.pc_write_cond, bus_w.i_or_d,
               bus_w.mem_read, bus_w.mem_write, bus_w.ir_write, bus_w.mem_to_reg,
               bus_w.reg_dst, bus_w.reg_write, bus_w.alu_src_a, bus_w.alu_src_b,
               bus_w.alu_op, bus_w.pc_source}), 32'(e.ctrl));
         check("instr_done", e.idx, 32'(bus_w.instr_done), 32'(e.done));
         check("illegal_op", e.idx, 32'(bus_w.illegal_op), 32'(e.ill));
         check("instr_count", e.idx, bus_w.instr_count, e.cnt);
         check("instr_count4", e.idx, 32'(bus_n.instr_count), 32'(e.cnt[3:0]));
      end
   end

   initial begin
      // Reset for two cycles
      cyc(1'b1, OpRtype, 1'b0, 0, 1'b0);
      cyc(1'b1, OpRtype, 1'b0, 0, 1'b0);
      // R-type: 0,1,6,7
      cyc(1'b0, OpRtype, 1'b1, 0, 1'b0);
      cyc(1'b0, OpRtype, 1'b1, 1, 1'b0);
      cyc(1'b0, OpRtype, 1'b1, 6, 1'b0);
      cyc(1'b0, OpRtype, 1'b1, 7, 1'b0);
      // lw with three wait cycles in MEMRD
      cyc(1'b0, OpLw, 1'b1, 0, 1'b0);
      cyc(1'b0, OpLw, 1'b1, 1, 1'b0);
      cyc(1'b0, OpLw, 1'b1, 2, 1'b0);
      cyc(1'b0, OpLw, 1'b0, 3, 1'b0);
      cyc(1'b0, OpLw, 1'b0, 3, 1'b0);
      cyc(1'b0, OpLw, 1'b0, 3, 1'b0);
      cyc(1'b0, OpLw, 1'b1, 3, 1'b0);
      cyc(1'b0, OpLw, 1'b1, 4, 1'b0);
      // sw with FETCH wait of 2 and one MEMWR wait
      cyc(1'b0, OpSw, 1'b0, 0, 1'b0);
      cyc(1'b0, OpSw, 1'b0, 0, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 0, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 1, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 2, 1'b0);
      cyc(1'b0, OpSw, 1'b0, 5, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 5, 1'b0);
      // beq (mem_ready low outside wait states is ignored), then j
      cyc(1'b0, OpBeq, 1'b1, 0, 1'b0);
      cyc(1'b0, OpBeq, 1'b0, 1, 1'b0);
      cyc(1'b0, OpBeq, 1'b0, 8, 1'b0);
      cyc(1'b0, OpJ, 1'b1, 0, 1'b0);
      cyc(1'b0, OpJ, 1'b1, 1, 1'b0);
      cyc(1'b0, OpJ, 1'b1, 9, 1'b0);
      // Illegal opcode
      cyc(1'b0, 6'h3F, 1'b1, 0, 1'b0);
      cyc(1'b0, 6'h3F, 1'b1, 1, 1'b1);
      // sw aborted by reset while waiting in MEMWR
      cyc(1'b0, OpSw, 1'b1, 0, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 1, 1'b0);
      cyc(1'b0, OpSw, 1'b1, 2, 1'b0);
      cyc(1'b0, OpSw, 1'b0, 5, 1'b0);
      cyc(1'b1, OpSw, 1'b0, 5, 1'b0);
      // 17 addi: narrow counter wraps to 1
      for (int i = 0; i < 17; i++) begin
         cyc(1'b0, OpAddi, 1'b1, 0, 1'b0);
         cyc(1'b0, OpAddi, 1'b1, 1, 1'b0);
         cyc(1'b0, OpAddi, 1'b1, 10, 1'b0);
         cyc(1'b0, OpAddi, 1'b1, 11, 1'b0);
      end
      cyc(1'b0, OpAddi, 1'b0, 0, 1'b0);
      cyc(1'b0, OpAddi, 1'b0, 0, 1'b0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
